// File: rtl/spi_scheduler_pkg.sv
// Shared definitions for the driver SPI scheduler, SPI master and register map.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_scheduler_pkg;

    // Datagram width of the driver SPI link.
    localparam int SPI_SIZE = 40;

    // Status-read datagram sent on every poll transfer.
    localparam logic [SPI_SIZE-1:0] POLL_WORD_DEFAULT = 40'h6F_0000_0000;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        SCHED_IDLE      = 3'd0,
        SCHED_LAUNCH    = 3'd1,
        SCHED_WAIT_ACK  = 3'd2,
        SCHED_WAIT_DONE = 3'd3,
        SCHED_FINISH    = 3'd4
    } sched_state_e;

endpackage

// File: rtl/spi_scheduler_if.sv
// Scheduler <-> SPI master link: send/ready handshake plus MOSI/MISO datagrams.
// Latency: wires only.
// Backpressure: the SPI master holds ready low while a datagram is in flight.
interface spi_scheduler_if #(
    parameter int SIZE     = 40,
    parameter int CS_WIDTH = 4
);
    logic                spi_ready_in;
    logic [SIZE-1:0]     spi_data_in;
    logic                r_spi_send_out;
    logic [CS_WIDTH-1:0] r_spi_cs_out;
    logic [SIZE-1:0]     r_spi_data_out;

    // Scheduler side.
    modport master (
        input  spi_ready_in,
        input  spi_data_in,
        output r_spi_send_out,
        output r_spi_cs_out,
        output r_spi_data_out
    );

    // SPI master side.
    modport slave (
        output spi_ready_in,
        output spi_data_in,
        input  r_spi_send_out,
        input  r_spi_cs_out,
        input  r_spi_data_out
    );
endinterface

// File: rtl/spi_scheduler_rr_pick.sv
// Rotate-priority encoder: first set mask bit strictly after i_last_idx, wrapping.
// Latency: combinational.
// Backpressure: none.
module spi_scheduler_rr_pick #(
    parameter int CS_SIZE  = 12,
    parameter int CS_WIDTH = 4
) (
    input  logic [CS_SIZE-1:0]  i_mask,
    input  logic [CS_WIDTH-1:0] i_last_idx,
    output logic [CS_WIDTH-1:0] o_next_idx,
    output logic                o_found
);

    localparam logic [CS_WIDTH:0] LP_SIZE = (CS_WIDTH+1)'(CS_SIZE);

    logic [2*CS_SIZE-1:0] w_dbl;
    logic [CS_WIDTH:0]    w_shift;
    logic [CS_SIZE-1:0]   w_rot;
    logic [CS_WIDTH-1:0]  w_off;
    logic [CS_WIDTH:0]    w_sum;

    // Rotate the mask so that bit 0 is the index right after i_last_idx.
    assign w_dbl   = {i_mask, i_mask};
    assign w_shift = {1'b0, i_last_idx} + 1'b1;
    assign w_rot   = CS_SIZE'(w_dbl >> w_shift);

    // Lowest set bit of the rotated mask is the smallest forward distance.
    always_comb begin
        o_found = 1'b0;
        w_off   = '0;
        for (int j = CS_SIZE - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                o_found = 1'b1;
                w_off   = CS_WIDTH'(j);
            end
        end
    end

    // Undo the rotation; the sum stays below 2*CS_SIZE so one wrap suffices.
    assign w_sum      = w_shift + {1'b0, w_off};
    assign o_next_idx = (w_sum >= LP_SIZE) ? CS_WIDTH'(w_sum - LP_SIZE) : CS_WIDTH'(w_sum);

endmodule

// File: rtl/spi_scheduler.sv
// Arbitrates the driver SPI master between the host port and the round-robin status poller.
// Latency: host_req_in to r_spi_send_out is 2 cycles; results pulse one cycle after SPI done.
// Backpressure: arbitrates only while spi_ready_in=1; host_req_in is ignored while busy.
module spi_scheduler
    import spi_scheduler_pkg::*;
#(
    parameter int                  SIZE        = SPI_SIZE,
    parameter int                  CS_SIZE     = 12,
    parameter int                  CS_WIDTH    = 4,
    parameter logic [15:0]         POLL_DIV    = 16'd50000,
    parameter logic [SIZE-1:0]     POLL_WORD   = POLL_WORD_DEFAULT,
    parameter logic [7:0]          ACK_TIMEOUT = 8'd255
) (
    input  logic                clk_in,
    input  logic                reset_in,
    input  logic                host_req_in,
    input  logic [CS_WIDTH-1:0] host_cs_in,
    input  logic [SIZE-1:0]     host_data_in,
    output logic                r_host_busy_out,
    output logic                r_host_done_out,
    output logic [SIZE-1:0]     r_host_data_out,
    input  logic                poll_enable_in,
    input  logic [CS_SIZE-1:0]  poll_mask_in,
    output logic                r_stat_valid_out,
    output logic [CS_WIDTH-1:0] r_stat_idx_out,
    output logic [SIZE-1:0]     r_stat_data_out,
    input  logic                err_clr_in,
    output logic                r_error_out,
    spi_scheduler_if.master     spi_bus
);

    localparam logic [2:0] ST_IDLE      = SCHED_IDLE;
    localparam logic [2:0] ST_LAUNCH    = SCHED_LAUNCH;
    localparam logic [2:0] ST_WAIT_ACK  = SCHED_WAIT_ACK;
    localparam logic [2:0] ST_WAIT_DONE = SCHED_WAIT_DONE;
    localparam logic [2:0] ST_FINISH    = SCHED_FINISH;

    localparam logic [CS_WIDTH:0]   LP_CS_LIMIT = (CS_WIDTH+1)'(CS_SIZE);
    localparam logic [CS_WIDTH-1:0] LP_LAST_RST = CS_WIDTH'(CS_SIZE - 1);

    logic [2:0]          r_state;
    logic [15:0]         r_poll_tmr;
    logic                r_poll_pend;
    logic [CS_WIDTH-1:0] r_last_idx;
    logic                r_served_host;
    logic                r_is_host;
    logic [CS_WIDTH-1:0] r_cur_cs;
    logic [SIZE-1:0]     r_cur_data;
    logic [SIZE-1:0]     r_cap_data;
    logic [7:0]          r_ack_cnt;

    logic                w_arb_ok;
    logic                w_host_win;
    logic                w_poll_win;
    logic                w_host_cs_bad;
    logic [CS_WIDTH-1:0] w_pick_idx;
    logic                w_pick_found;
    logic                w_poll_exp;
    logic                w_poll_clr;
    logic                w_ack_to;
    logic                w_err_set;

    spi_scheduler_rr_pick #(
        .CS_SIZE  (CS_SIZE),
        .CS_WIDTH (CS_WIDTH)
    ) u_rr_pick (
        .i_mask     (poll_mask_in),
        .i_last_idx (r_last_idx),
        .o_next_idx (w_pick_idx),
        .o_found    (w_pick_found)
    );

    // Host wins contention unless it took the previous slot.
    assign w_arb_ok      = (r_state == ST_IDLE) && spi_bus.spi_ready_in;
    assign w_host_win    = w_arb_ok && host_req_in && !(r_poll_pend && r_served_host);
    assign w_poll_win    = w_arb_ok && r_poll_pend && !w_host_win;
    assign w_host_cs_bad = ({1'b0, host_cs_in} >= LP_CS_LIMIT);

    assign w_poll_exp = poll_enable_in && (POLL_DIV != 16'd0) && (r_poll_tmr <= 16'd1);
    assign w_poll_clr = ((r_state == ST_FINISH) && !r_is_host) || (w_poll_win && !w_pick_found);

    assign w_ack_to  = (({1'b0, r_ack_cnt} + 9'd1) >= {1'b0, ACK_TIMEOUT});
    assign w_err_set = (w_host_win && w_host_cs_bad) ||
                       ((r_state == ST_WAIT_ACK) && spi_bus.spi_ready_in && w_ack_to);

    // Poll slot timer; a new expiry outranks the clear of a just-served slot.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_poll_tmr  <= POLL_DIV;
            r_poll_pend <= 1'b0;
        end else begin
            if (!poll_enable_in || (POLL_DIV == 16'd0) || (r_poll_tmr <= 16'd1)) begin
                r_poll_tmr <= POLL_DIV;
            end else begin
                r_poll_tmr <= r_poll_tmr - 16'd1;
            end
            if (w_poll_exp) begin
                r_poll_pend <= 1'b1;
            end else if (w_poll_clr) begin
                r_poll_pend <= 1'b0;
            end
        end
    end

    // Sticky error flag; a new error outranks a simultaneous clear.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_error_out <= 1'b0;
        end else if (w_err_set) begin
            r_error_out <= 1'b1;
        end else if (err_clr_in) begin
            r_error_out <= 1'b0;
        end
    end

    // Transfer sequencer: grant, launch, handshake with the SPI master, publish result.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state                <= ST_IDLE;
            r_last_idx             <= LP_LAST_RST;
            r_served_host          <= 1'b0;
            r_is_host              <= 1'b0;
            r_cur_cs               <= '0;
            r_cur_data             <= '0;
            r_cap_data             <= '0;
            r_ack_cnt              <= '0;
            r_host_busy_out        <= 1'b0;
            r_host_done_out        <= 1'b0;
            r_host_data_out        <= '0;
            r_stat_valid_out       <= 1'b0;
            r_stat_idx_out         <= '0;
            r_stat_data_out        <= '0;
            spi_bus.r_spi_send_out <= 1'b0;
            spi_bus.r_spi_cs_out   <= '0;
            spi_bus.r_spi_data_out <= '0;
        end else begin
            r_host_done_out  <= 1'b0;
            r_stat_valid_out <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_host_win) begin
                        r_host_busy_out <= 1'b1;
                        r_is_host       <= 1'b1;
                        r_cur_cs        <= host_cs_in;
                        r_cur_data      <= host_data_in;
                        if (w_host_cs_bad) begin
                            r_cap_data <= '0;
                            r_state    <= ST_FINISH;
                        end else begin
                            r_state    <= ST_LAUNCH;
                        end
                    end else if (w_poll_win) begin
                        if (w_pick_found) begin
                            r_is_host  <= 1'b0;
                            r_cur_cs   <= w_pick_idx;
                            r_cur_data <= POLL_WORD;
                            r_state    <= ST_LAUNCH;
                        end else begin
                            // Empty mask still consumes the poll slot.
                            r_served_host <= 1'b0;
                        end
                    end
                end
                ST_LAUNCH: begin
                    spi_bus.r_spi_cs_out   <= r_cur_cs;
                    spi_bus.r_spi_data_out <= r_cur_data;
                    spi_bus.r_spi_send_out <= 1'b1;
                    r_ack_cnt              <= '0;
                    r_state                <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (!spi_bus.spi_ready_in) begin
                        spi_bus.r_spi_send_out <= 1'b0;
                        r_state                <= ST_WAIT_DONE;
                    end else if (w_ack_to) begin
                        spi_bus.r_spi_send_out <= 1'b0;
                        r_cap_data             <= '0;
                        r_state                <= ST_FINISH;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 8'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (spi_bus.spi_ready_in) begin
                        r_cap_data <= spi_bus.spi_data_in;
                        r_state    <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    if (r_is_host) begin
                        r_host_done_out <= 1'b1;
                        r_host_data_out <= r_cap_data;
                        r_host_busy_out <= 1'b0;
                        r_served_host   <= 1'b1;
                    end else begin
                        r_stat_valid_out <= 1'b1;
                        r_stat_idx_out   <= r_cur_cs;
                        r_stat_data_out  <= r_cap_data;
                        r_last_idx       <= r_cur_cs;
                        r_served_host    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_scheduler.sv
// Self-checking bench for spi_scheduler: SPI master model, poll scoreboard, host/poll scenarios.
// Latency: n/a.
// Backpressure: the SPI model holds ready low for a random or fixed number of cycles.
module tb_spi_scheduler;
    import spi_scheduler_pkg::*;

    localparam int          CSN = 12;
    localparam logic [39:0] PW  = 40'h6F_0000_0000;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        host_req_in = 1'b0;
    logic [3:0]  host_cs_in = '0;
    logic [39:0] host_data_in = '0;
    logic        r_host_busy_out;
    logic        r_host_done_out;
    logic [39:0] r_host_data_out;
    logic        poll_enable_in = 1'b0;
    logic [11:0] poll_mask_in = '0;
    logic        r_stat_valid_out;
    logic [3:0]  r_stat_idx_out;
    logic [39:0] r_stat_data_out;
    logic        err_clr_in = 1'b0;
    logic        r_error_out;

    spi_scheduler_if #(.SIZE(40), .CS_WIDTH(4)) sif ();

    spi_scheduler #(.POLL_DIV(16'd10)) dut (
        .clk_in           (clk_in),
        .reset_in         (reset_in),
        .host_req_in      (host_req_in),
        .host_cs_in       (host_cs_in),
        .host_data_in     (host_data_in),
        .r_host_busy_out  (r_host_busy_out),
        .r_host_done_out  (r_host_done_out),
        .r_host_data_out  (r_host_data_out),
        .poll_enable_in   (poll_enable_in),
        .poll_mask_in     (poll_mask_in),
        .r_stat_valid_out (r_stat_valid_out),
        .r_stat_idx_out   (r_stat_idx_out),
        .r_stat_data_out  (r_stat_data_out),
        .err_clr_in       (err_clr_in),
        .r_error_out      (r_error_out),
        .spi_bus          (sif)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    typedef struct {
        logic [3:0]  cs;
        logic [39:0] mosi;
        logic [39:0] miso;
    } xfer_t;

    xfer_t       xq[$];
    int          stat_log[$];
    int          kinds[$];          // 0 = host completion, 1 = poll completion
    int          last_idx_m = CSN - 1;
    bit          spi_ack_en = 1'b1;
    bit          fix_rsp = 1'b0;
    logic [39:0] rsp_val = '0;
    int          ack_dly_fix = 0;
    int          done_dly_fix = 0;

    // Next enabled driver strictly after 'last', wrapping; -1 when the mask is empty.
    function automatic int next_idx(input logic [11:0] m, input int last);
        for (int k = 1; k <= CSN; k++) begin
            if (((m >> ((last + k) % CSN)) & 12'd1) != 12'd0) return (last + k) % CSN;
        end
        return -1;
    endfunction

    // SPI master model: on send, drop ready after an ack delay, return MISO after a busy time.
    initial begin : spi_model
        xfer_t x;
        int    a;
        int    d;
        sif.spi_ready_in = 1'b1;
        sif.spi_data_in  = '0;
        forever begin
            @(negedge clk_in);
            if (spi_ack_en && sif.r_spi_send_out && sif.spi_ready_in) begin
                x.cs   = sif.r_spi_cs_out;
                x.mosi = sif.r_spi_data_out;
                x.miso = fix_rsp ? rsp_val : {8'($urandom), $urandom};
                a = (ack_dly_fix != 0) ? ack_dly_fix : int'($urandom_range(1, 4));
                d = (done_dly_fix != 0) ? done_dly_fix : int'($urandom_range(3, 30));
                xq.push_back(x);
                repeat (a) @(negedge clk_in);
                sif.spi_ready_in = 1'b0;
                repeat (d) @(negedge clk_in);
                sif.spi_data_in  = x.miso;
                sif.spi_ready_in = 1'b1;
            end
        end
    end

    // Poll scoreboard: every status pulse must target the model's next driver with POLL_WORD.
    initial begin : stat_mon
        xfer_t x;
        int    e;
        forever begin
            @(negedge clk_in);
            if (!reset_in && r_stat_valid_out) begin
                e = next_idx(poll_mask_in, last_idx_m);
                chk("stat_idx", 64'(r_stat_idx_out), 64'(e));
                if (e >= 0) last_idx_m = e;
                stat_log.push_back(int'(r_stat_idx_out));
                kinds.push_back(1);
                chk("stat_xfer_q", 64'(xq.size() > 0), 64'(1));
                if (xq.size() > 0) begin
                    x = xq.pop_front();
                    chk("stat_spi_cs", 64'(x.cs), 64'(e));
                    chk("stat_mosi", 64'(x.mosi), 64'(PW));
                    chk("stat_data", 64'(r_stat_data_out), 64'(x.miso));
                end
            end
        end
    end

    task automatic check_host_done(input logic [3:0] cs, input logic [39:0] d, input bit acked);
        xfer_t x;
        chk("host_busy_clr", 64'(r_host_busy_out), 64'(0));
        if (int'(cs) >= CSN || !acked) begin
            chk("host_data_zero", 64'(r_host_data_out), 64'(0));
            chk("host_err_set", 64'(r_error_out), 64'(1));
        end else begin
            chk("host_xfer_q", 64'(xq.size() > 0), 64'(1));
            if (xq.size() > 0) begin
                x = xq.pop_front();
                chk("host_spi_cs", 64'(x.cs), 64'(cs));
                chk("host_mosi", 64'(x.mosi), 64'(d));
                chk("host_data", 64'(r_host_data_out), 64'(x.miso));
            end
        end
        kinds.push_back(0);
    endtask

    task automatic host_xfer(input logic [3:0] cs, input logic [39:0] d, input bit acked,
                             output int sends);
        bit got;
        got   = 1'b0;
        sends = 0;
        @(negedge clk_in);
        host_cs_in   = cs;
        host_data_in = d;
        host_req_in  = 1'b1;
        for (int n = 0; n < 4000 && !got; n++) begin
            @(negedge clk_in);
            if (sif.r_spi_send_out) sends++;
            if (r_host_done_out) begin
                host_req_in = 1'b0;
                got = 1'b1;
                check_host_done(cs, d, acked);
            end
        end
        host_req_in = 1'b0;
        chk("host_done_seen", 64'(got), 64'(1));
    endtask

    task automatic clr_err();
        @(negedge clk_in);
        err_clr_in = 1'b1;
        @(negedge clk_in);
        err_clr_in = 1'b0;
        chk("err_clr", 64'(r_error_out), 64'(0));
    endtask

    task automatic drain();
        poll_enable_in = 1'b0;
        repeat (150) @(negedge clk_in);
    endtask

    initial begin : main
        int          sends;
        int          cnt;
        int          s0;
        int          ks;
        bit          got;
        bit          seen;
        logic [3:0]  cs;
        logic [39:0] d;
        int          exp2[4] = '{0, 2, 11, 0};

        // Reset state.
        repeat (3) @(negedge clk_in);
        chk("rst_busy", 64'(r_host_busy_out), 64'(0));
        chk("rst_done", 64'(r_host_done_out), 64'(0));
        chk("rst_stat_valid", 64'(r_stat_valid_out), 64'(0));
        chk("rst_send", 64'(sif.r_spi_send_out), 64'(0));
        chk("rst_err", 64'(r_error_out), 64'(0));
        reset_in = 1'b0;
        repeat (2) @(negedge clk_in);

        // 1: host transfer, exact launch latency and fixed MISO.
        fix_rsp = 1'b1; rsp_val = 40'h12_3456_789A; ack_dly_fix = 2; done_dly_fix = 40;
        d = 40'h80_0000_00AA;
        host_cs_in = 4'd3; host_data_in = d; host_req_in = 1'b1;
        @(negedge clk_in);
        chk("t1_busy", 64'(r_host_busy_out), 64'(1));
        chk("t1_send_early", 64'(sif.r_spi_send_out), 64'(0));
        @(negedge clk_in);
        chk("t1_send_lat", 64'(sif.r_spi_send_out), 64'(1));
        chk("t1_cs", 64'(sif.r_spi_cs_out), 64'(3));
        chk("t1_mosi", 64'(sif.r_spi_data_out), 64'(d));
        got = 1'b0;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk_in);
            if (r_host_done_out) begin
                host_req_in = 1'b0;
                got = 1'b1;
                chk("t1_data", 64'(r_host_data_out), 64'h12_3456_789A);
                check_host_done(4'd3, d, 1'b1);
            end
        end
        host_req_in = 1'b0;
        chk("t1_done_seen", 64'(got), 64'(1));
        cnt = 0;
        repeat (20) begin
            @(negedge clk_in);
            if (r_host_done_out) cnt++;
        end
        chk("t1_done_once", 64'(cnt), 64'(0));
        chk("t1_busy_low", 64'(r_host_busy_out), 64'(0));
        fix_rsp = 1'b0; ack_dly_fix = 0; done_dly_fix = 0;

        // 2: poll order over a sparse mask.
        poll_mask_in = 12'b1000_0000_0101;
        s0 = stat_log.size();
        poll_enable_in = 1'b1;
        for (int n = 0; n < 3000 && stat_log.size() < s0 + 4; n++) @(negedge clk_in);
        chk("t2_polls_seen", 64'(stat_log.size() >= s0 + 4), 64'(1));
        for (int i = 0; i < 4; i++) begin
            if (stat_log.size() > s0 + i) chk("t2_idx", 64'(stat_log[s0 + i]), 64'(exp2[i]));
        end
        drain();

        // Randomised rounds: random masks, host targets (some invalid) and gaps.
        for (int r = 0; r < 5; r++) begin
            poll_mask_in = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
            poll_enable_in = 1'b1;
            for (int k = 0; k < 4; k++) begin
                cs = 4'($urandom_range(0, 13));
                d  = {8'($urandom), $urandom};
                host_xfer(cs, d, 1'b1, sends);
                if (int'(cs) >= CSN) begin
                    chk("rnd_bad_cs_sends", 64'(sends), 64'(0));
                    clr_err();
                end else begin
                    chk("rnd_err_quiet", 64'(r_error_out), 64'(0));
                end
                repeat ($urandom_range(0, 20)) @(negedge clk_in);
            end
            drain();
        end

        // 3: host held high against a busy poller must alternate with it.
        poll_mask_in = 12'($urandom_range(1, 4095));
        poll_enable_in = 1'b1;
        repeat (12) @(negedge clk_in);
        cs = 4'($urandom_range(0, 11));
        d  = {8'($urandom), $urandom};
        host_cs_in = cs; host_data_in = d; host_req_in = 1'b1;
        ks  = kinds.size();
        cnt = 0;
        for (int n = 0; n < 6000 && cnt < 8; n++) begin
            @(negedge clk_in);
            if (r_host_done_out) begin
                check_host_done(cs, d, 1'b1);
                cnt++;
            end
            if (r_stat_valid_out) cnt++;
            if (cnt >= 8) host_req_in = 1'b0;
        end
        host_req_in = 1'b0;
        chk("t3_events", 64'(cnt), 64'(8));
        drain();
        for (int i = ks + 1; i < ks + 8 && i < kinds.size(); i++) begin
            chk("t3_alternate", 64'(kinds[i] != kinds[i - 1]), 64'(1));
        end

        // 4: SPI master never acks -> timeout after ACK_TIMEOUT cycles of send.
        chk("t4_err_pre", 64'(r_error_out), 64'(0));
        spi_ack_en = 1'b0;
        host_xfer(4'd5, 40'hAB_CDEF_0123, 1'b0, sends);
        chk("t4_send_cycles", 64'(sends), 64'(255));
        spi_ack_en = 1'b1;
        clr_err();

        // 5: invalid chip select -> no SPI activity, zero data, error.
        host_xfer(4'd13, 40'h11_2233_4455, 1'b1, sends);
        chk("t5_sends", 64'(sends), 64'(0));
        clr_err();

        // 6: reset during WAIT_DONE, then normal operation resumes.
        ack_dly_fix = 2; done_dly_fix = 40;
        @(negedge clk_in);
        host_cs_in = 4'd2; host_data_in = 40'h55_AA55_AA55; host_req_in = 1'b1;
        seen = 1'b0; got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk_in);
            if (sif.r_spi_send_out) seen = 1'b1;
            else if (seen) got = 1'b1;
        end
        chk("t6_in_wait_done", 64'(got), 64'(1));
        repeat (5) @(negedge clk_in);
        chk("t6_busy_pre", 64'(r_host_busy_out), 64'(1));
        reset_in = 1'b1;
        #1;
        chk("t6_rst_busy", 64'(r_host_busy_out), 64'(0));
        chk("t6_rst_send", 64'(sif.r_spi_send_out), 64'(0));
        chk("t6_rst_spi_cs", 64'(sif.r_spi_cs_out), 64'(0));
        chk("t6_rst_spi_data", 64'(sif.r_spi_data_out), 64'(0));
        chk("t6_rst_err", 64'(r_error_out), 64'(0));
        host_req_in = 1'b0;
        @(negedge clk_in);
        reset_in = 1'b0;
        last_idx_m = CSN - 1;
        got = 1'b0;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk_in);
            if (sif.spi_ready_in) got = 1'b1;
        end
        chk("t6_spi_idle", 64'(got), 64'(1));
        xq.delete();
        ack_dly_fix = 0; done_dly_fix = 0;
        host_xfer(4'd7, 40'h0F_F00F_F00F, 1'b1, sends);
        poll_mask_in = 12'b1000_0000_0101;
        s0 = stat_log.size();
        poll_enable_in = 1'b1;
        for (int n = 0; n < 1000 && stat_log.size() <= s0; n++) @(negedge clk_in);
        chk("t6_poll_seen", 64'(stat_log.size() > s0), 64'(1));
        if (stat_log.size() > s0) chk("t6_poll_first_idx", 64'(stat_log[s0]), 64'(0));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/spi_scheduler.md
Name: spi_scheduler

Overview:
Arbitrates the single 40-bit driver SPI master between two requesters: a CPU host port (register-mapped) and an autonomous status poller. The poller round-robin reads a fixed status datagram from every enabled stepper driver chip select. The block sequences each transfer through the SPI master's send/ready handshake and returns captured MISO data. It runs on the same clock as the SPI master and sits between the SPI config/data registers and the SPI instance.

Parameters:
SIZE, 40, SPI datagram width in bits
CS_SIZE, 12, number of driver chip selects; valid indices are 0..CS_SIZE-1
CS_WIDTH, 4, chip-select index width
POLL_DIV, 16'd50000, clock cycles between poll slots; 0 disables poll timer
POLL_WORD, 40'h6F00000000, MOSI datagram sent on every poll transfer
ACK_TIMEOUT, 8'd255, cycles to wait for the SPI master to drop ready after a send

Ports:
clk_in  in  1  clock, same domain as SPI master
reset_in  in  1  asynchronous, active-high reset
host_req_in  in  1  host transfer request (level, sampled only in IDLE)
host_cs_in  in  CS_WIDTH  host target chip-select index
host_data_in  in  SIZE  host MOSI datagram
r_host_busy_out  out  1  host transfer accepted and not yet complete
r_host_done_out  out  1  one-cycle pulse when host transfer completes
r_host_data_out  out  SIZE  MISO data of the last host transfer
poll_enable_in  in  1  enables the autonomous poller
poll_mask_in  in  CS_SIZE  per-driver poll enable
r_stat_valid_out  out  1  one-cycle pulse, poll result valid
r_stat_idx_out  out  CS_WIDTH  index of the polled driver
r_stat_data_out  out  SIZE  polled MISO datagram
spi_ready_in  in  1  SPI master idle/done
spi_data_in  in  SIZE  SPI master received data
r_spi_send_out  out  1  SPI send enable
r_spi_cs_out  out  CS_WIDTH  SPI chip-select index
r_spi_data_out  out  SIZE  SPI MOSI datagram
err_clr_in  in  1  clears r_error_out
r_error_out  out  1  sticky error: timeout or invalid host cs

Behaviour:
- Reset (async, active-high): all r_* outputs 0, FSM to IDLE, poll timer to POLL_DIV, poll_pending 0, last_idx to CS_SIZE-1, served_host flag 0. Reset mid-transfer drops r_spi_send_out immediately.
- Poll timer: counts down when poll_enable_in=1 and POLL_DIV!=0. On reaching 0, sets poll_pending and reloads. It is held at POLL_DIV while disabled. An expiry while poll_pending is already set is absorbed and not queued.
- FSM states: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, FINISH.
- IDLE: arbitration runs only when spi_ready_in=1.
  - host_req_in and poll_pending both set: host wins unless served_host=1, in which case poll wins. served_host is set after a host transfer and cleared after a poll slot, giving strict alternation under contention.
  - Host grant: latch cs/data and set r_host_busy_out next cycle.
  - Host cs >= CS_SIZE: no SPI activity. Go straight to FINISH with data 0 and set r_error_out.
  - Poll grant: pick the next set bit of poll_mask_in strictly after last_idx, wrapping. The mask is sampled at this cycle. Drive POLL_WORD. If the mask is all zero, clear poll_pending with no transfer.
- LAUNCH (1 cycle): drive r_spi_cs_out and r_spi_data_out, assert r_spi_send_out, then go to WAIT_ACK. cs/data are held stable until FINISH.
- WAIT_ACK: r_spi_send_out stays high until spi_ready_in=0, then deassert and go to WAIT_DONE.
  - After ACK_TIMEOUT cycles without ack: deassert send, set r_error_out, go to FINISH with captured data 0.
- WAIT_DONE: wait for spi_ready_in=1 (no timeout), capture spi_data_in, go to FINISH.
- FINISH (1 cycle), host transfer: r_host_done_out=1, r_host_data_out updated, r_host_busy_out cleared.
- FINISH (1 cycle), poll transfer: r_stat_valid_out=1 with idx/data, last_idx updated, poll_pending cleared.
- FINISH always returns to IDLE. Back-to-back: minimum one IDLE cycle between transfers.
- Latency: host_req_in to r_spi_send_out = 2 cycles with spi_ready_in high.
- r_error_out: set by timeout or invalid cs; cleared by err_clr_in. If set and clear occur in the same cycle, set wins.
- host_req_in changes while busy are ignored. A level still high after done starts a new transfer.

Decomposition:
- Shared package: FSM state enum, default POLL_WORD constant, SPI datagram width constant (shared with the SPI master and register map).
- Sub-module rr_pick: combinational rotate-priority encoder (mask, last_idx -> next_idx, found). Parameterised by CS_SIZE/CS_WIDTH; reusable by future driver-enable sequencers.

Test Plan:
1. Host request, cs=3, data=40'h80_0000_00AA; SPI model acks after 2 cycles and returns 40'h12_3456_789A after 40 cycles -> send high 2 cycles after req. r_spi_cs_out=3, done pulse once, r_host_data_out=40'h123456789A, busy low after.
2. Poll enabled, POLL_DIV=10, mask=12'b1000_0000_0101 -> slots target idx 0, 2, 11, 0 in order. Each r_spi_data_out=POLL_WORD, each stat_valid carries the matching idx.
3. Host req held high while poll_pending set -> host, poll, host, poll alternation. No requester is starved.
4. SPI model never drops ready -> send deasserts after 255 cycles, r_error_out=1, done pulse with data 0. err_clr_in clears the error.
5. host_cs_in=13 -> no r_spi_send_out, done pulse in FINISH with data 0, r_error_out=1.
6. reset_in asserted during WAIT_DONE -> all outputs 0 asynchronously. After release, a new host transfer completes normally and poll restarts at idx 0.
